vector_arbiter: RTL and testbench

- Shares one `vector_buffer` consumer port (`req` / `vector` / `valid`) between `NB_CLIENTS` requesters.
- Uses round-robin arbitration.
- Issues single-cycle pop requests to the buffer and routes the returned vector to the granted client.
- Retries a bounded number of times when the buffer reports empty.
- Sits between the vector buffer and the downstream compute units.

---
 rtl/vector_pkg.sv | 20 ++
 rtl/vector_arbiter_rr_pick.sv | 36 +++
 rtl/vector_arbiter.sv | 131 +++++++++++++
 tb/tb_vector_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector arbiter slice.
//   VEC_W_DEF   : default vector width, matches the vector buffer
//   arb_state_e : arbiter FSM state encoding
//   idx_width   : index width helper, never narrower than 1 bit
package vector_pkg;

  localparam int VEC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority pick.
//   req_i : per-client request vector
//   ptr_i : client index where the search starts (must be < NB_CLIENTS)
//   any_o : at least one request is set
//   idx_o : first requesting index at or after ptr_i, wrapping
module rr_pick
  import vector_pkg::*;
#(
  parameter int NB_CLIENTS = 4,
  localparam int IDX_W = idx_width(NB_CLIENTS)
) (
  input  logic [NB_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic                  any_o,
  output logic [IDX_W-1:0]      idx_o
);

  int cand;

  // Walk offsets from the far end back to the pointer so the smallest
  // offset with a request is the last one written.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int i = NB_CLIENTS - 1; i >= 0; i--) begin
      cand = int'(ptr_i) + i;
      if (cand >= NB_CLIENTS) cand = cand - NB_CLIENTS;
      if (req_i[IDX_W'(cand)]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vector_arbiter.sv
// vector_arbiter: shares one vector_buffer pop port between NB_CLIENTS
// requesters with round-robin arbitration and bounded retry on empty.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   cli_req_i     : per-client level request, sampled only in IDLE
//   cli_ack_o     : one-hot pulse, cli_vector_o valid for that client
//   cli_empty_o   : one-hot pulse, every attempt found the buffer empty
//   cli_vector_o  : returned vector, zero when no ack
//   buf_req_o     : single-cycle pop request to the buffer
//   buf_vector_i, buf_valid_i : buffer response, the cycle after buf_req_o
//
// state | meaning
// IDLE  | waiting for a request, picks winner round-robin
// ISSUE | buf_req_o high for this cycle
// WAIT  | buffer response sampled; ack, retry or give up
// DONE  | ack/empty pulse on the outputs, pointer moves past the winner
module vector_arbiter
  import vector_pkg::*;
#(
  parameter int NB_CLIENTS = 4,
  parameter int VEC_W      = VEC_W_DEF,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_CLIENTS-1:0] cli_req_i,
  output logic [NB_CLIENTS-1:0] cli_ack_o,
  output logic [NB_CLIENTS-1:0] cli_empty_o,
  output logic [VEC_W-1:0]      cli_vector_o,
  output logic                  buf_req_o,
  input  logic [VEC_W-1:0]      buf_vector_i,
  input  logic                  buf_valid_i
);

  localparam int IDX_W = idx_width(NB_CLIENTS);
  localparam int RTY_W = idx_width(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_CLIENTS - 1);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic [NB_CLIENTS-1:0] ack_q, ack_d;
  logic [NB_CLIENTS-1:0] empty_q, empty_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  logic                  buf_req_q, buf_req_d;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_idx;
  logic [NB_CLIENTS-1:0] grant_oh;

  rr_pick #(.NB_CLIENTS(NB_CLIENTS)) u_pick (
    .req_i (cli_req_i),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign grant_oh = {{(NB_CLIENTS-1){1'b0}}, 1'b1} << grant_q;

  // Outputs are all registered: the pulses are computed on the transition
  // into the state where they must be visible.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    retry_d   = retry_q;
    ack_d     = '0;
    empty_d   = '0;
    vec_d     = '0;
    buf_req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d   = pick_idx;
          retry_d   = '0;
          buf_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (buf_valid_i) begin
          ack_d   = grant_oh;
          vec_d   = buf_vector_i;
          state_d = ST_DONE;
        end else if (retry_q < RTY_LAST) begin
          retry_d   = retry_q + 1'b1;
          buf_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          empty_d = grant_oh;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      retry_q   <= '0;
      ack_q     <= '0;
      empty_q   <= '0;
      vec_q     <= '0;
      buf_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      retry_q   <= retry_d;
      ack_q     <= ack_d;
      empty_q   <= empty_d;
      vec_q     <= vec_d;
      buf_req_q <= buf_req_d;
    end
  end

  assign cli_ack_o    = ack_q;
  assign cli_empty_o  = empty_q;
  assign cli_vector_o = vec_q;
  assign buf_req_o    = buf_req_q;

endmodule

// File: tb/tb_vector_arbiter.sv
// Testbench for vector_arbiter: directed table of transactions, a few
// hand-written reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_vector_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cli_req = '0;
  logic [N-1:0] cli_ack, cli_empty;
  logic [W-1:0] cli_vector;
  logic         buf_req;
  logic [W-1:0] buf_vector = '0;
  logic         buf_valid = 1'b0;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  vector_arbiter #(.NB_CLIENTS(N), .VEC_W(W), .MAX_RETRY(MR)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cli_req_i    (cli_req),
    .cli_ack_o    (cli_ack),
    .cli_empty_o  (cli_empty),
    .cli_vector_o (cli_vector),
    .buf_req_o    (buf_req),
    .buf_vector_i (buf_vector),
    .buf_valid_i  (buf_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cli_req = '1; buf_valid = 1'b1; buf_vector = 8'h5C;
    @(negedge clk);
    chk("rst_ack", 32'(cli_ack), 0);
    chk("rst_empty", 32'(cli_empty), 0);
    chk("rst_vector", 32'(cli_vector), 0);
    chk("rst_buf_req", 32'(buf_req), 0);
    rst = 1'b0; cli_req = '0; buf_valid = 1'b0; buf_vector = '0;
  endtask

  // One transaction from an idle DUT. The buffer answers the cycle after
  // each buf_req with the next entry of vmask; outside those cycles it
  // drives junk with valid set, which the arbiter must ignore.
  task automatic do_txn(input logic [N-1:0] req, input logic [N-1:0] drop,
                        input logic [MR:0] vmask, input logic [W-1:0] vec,
                        output logic [N-1:0] ack, output logic [N-1:0] empty,
                        output logic [W-1:0] vout, output logic [15:0] pmask,
                        output int t_end, output int at, output logic quiet);
    int att;
    logic due;
    logic done;
    att = 0; due = 1'b0; done = 1'b0; quiet = 1'b1;
    ack = '0; empty = '0; vout = '0; pmask = '0; t_end = -1; at = -1;
    @(negedge clk);
    cli_req = req; buf_valid = 1'b1; buf_vector = 8'h99;
    for (int t = 1; t <= 2 * (MR + 1) + 3 && !done; t++) begin
      @(negedge clk);
      if (buf_req) pmask[t] = 1'b1;
      if (cli_ack != 0 || cli_empty != 0) begin
        ack = cli_ack; empty = cli_empty; vout = cli_vector;
        t_end = t; at = cyc; done = 1'b1;
      end else if (cli_vector != 0) begin
        quiet = 1'b0;
      end
      cli_req = req & ~drop;
      if (due && att <= MR) begin
        buf_valid  = vmask[att];
        buf_vector = vmask[att] ? vec : 8'hC3;
        att++;
      end else begin
        buf_valid = 1'b1; buf_vector = 8'h99;
      end
      due = buf_req;
    end
  endtask

  typedef struct {
    logic        rst_first;
    logic [N-1:0] req;
    logic [N-1:0] drop;
    logic [MR:0] vmask;
    logic [W-1:0] vec;
    logic [N-1:0] ack;
    logic [N-1:0] empty;
    logic [W-1:0] vout;
    logic [15:0] pmask;
    int          t_end;
    int          gap;
  } vec_t;

  vec_t tbl [11];

  task automatic run_table();
    logic [N-1:0] a, e;
    logic [W-1:0] v;
    logic [15:0]  pm;
    int te, at, prev_at;
    logic q;
    prev_at = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_first) do_reset();
      do_txn(tbl[i].req, tbl[i].drop, tbl[i].vmask, tbl[i].vec, a, e, v, pm, te, at, q);
      chk($sformatf("tbl%0d_ack", i), 32'(a), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_empty", i), 32'(e), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d_vector", i), 32'(v), 32'(tbl[i].vout));
      chk($sformatf("tbl%0d_bufreq_cycles", i), 32'(pm), 32'(tbl[i].pmask));
      chk($sformatf("tbl%0d_latency", i), 32'(te), 32'(tbl[i].t_end));
      chk($sformatf("tbl%0d_quiet", i), 32'(q), 1);
      if (tbl[i].gap > 0) chk($sformatf("tbl%0d_gap", i), 32'(at - prev_at), 32'(tbl[i].gap));
      prev_at = at;
    end
  endtask

  task automatic run_reset_in_wait();
    logic [N-1:0] a, e;
    logic [W-1:0] v;
    logic [15:0]  pm;
    int te, at;
    logic q;
    do_txn(4'h1, 4'h0, 4'b0001, 8'h11, a, e, v, pm, te, at, q);
    chk("pre_rst_ack", 32'(a), 1);
    @(negedge clk);
    cli_req = 4'hF; buf_valid = 1'b0; buf_vector = '0;
    @(negedge clk);
    chk("wrst_issue_bufreq", 32'(buf_req), 1);
    @(negedge clk);
    rst = 1'b1; buf_valid = 1'b1; buf_vector = 8'hE7;
    @(negedge clk);
    chk("wrst_ack", 32'(cli_ack), 0);
    chk("wrst_empty", 32'(cli_empty), 0);
    chk("wrst_vector", 32'(cli_vector), 0);
    chk("wrst_bufreq", 32'(buf_req), 0);
    rst = 1'b0; cli_req = '0; buf_valid = 1'b0; buf_vector = '0;
    do_txn(4'hF, 4'h0, 4'b0001, 8'h42, a, e, v, pm, te, at, q);
    chk("post_rst_ack", 32'(a), 1);
    chk("post_rst_vector", 32'(v), 32'h42);
    chk("post_rst_latency", 32'(te), 3);
    chk("post_rst_quiet", 32'(q), 1);
  endtask

  // Transaction-level model: on a sampled request the winner, the attempt
  // outcomes and hence the whole timeline are fixed up front; expected
  // outputs per cycle follow from the offset within that timeline.
  task automatic run_random(input int ncyc);
    logic         m_busy, m_ok;
    int           m_start, m_n, m_win, m_ptr, m_next, d, a;
    logic [W-1:0] m_data;
    logic         rv [MR+1];
    logic [W-1:0] rd [MR+1];
    logic [N-1:0] e_ack, e_emp;
    logic [W-1:0] e_vec;
    logic         e_req;
    m_busy = 1'b0; m_ok = 1'b0; m_start = 0; m_n = 0; m_win = 0;
    m_ptr = 0; m_data = '0;
    do_reset();
    m_next = cyc + 1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e_ack = '0; e_emp = '0; e_vec = '0; e_req = 1'b0;
      d = cyc - m_start;
      if (m_busy) begin
        if (d >= 1 && d <= 2 * m_n - 1 && (d % 2) == 1) e_req = 1'b1;
        if (d == 2 * m_n + 1) begin
          if (m_ok) begin
            e_ack = N'(1 << m_win);
            e_vec = m_data;
          end else begin
            e_emp = N'(1 << m_win);
          end
          m_busy = 1'b0;
        end
      end
      chk("rnd_ack", 32'(cli_ack), 32'(e_ack));
      chk("rnd_empty", 32'(cli_empty), 32'(e_emp));
      chk("rnd_vector", 32'(cli_vector), 32'(e_vec));
      chk("rnd_bufreq", 32'(buf_req), 32'(e_req));

      cli_req = ($urandom_range(0, 9) < 3) ? '0 : N'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        buf_valid = 1'($urandom_range(0, 1));
        buf_vector = W'($urandom);
        m_busy = 1'b0; m_ptr = 0; m_next = cyc + 1;
        continue;
      end
      rst = 1'b0;
      if (m_busy && d >= 2 && d <= 2 * m_n && (d % 2) == 0) begin
        a = d / 2 - 1;
        buf_valid  = rv[a];
        buf_vector = rv[a] ? rd[a] : W'($urandom);
      end else begin
        buf_valid  = 1'($urandom_range(0, 1));
        buf_vector = W'($urandom);
      end
      if (!m_busy && cyc >= m_next && cli_req != 0) begin
        for (int i = 0; i < N; i++) begin
          if (cli_req[(m_ptr + i) % N]) begin
            m_win = (m_ptr + i) % N;
            break;
          end
        end
        m_n = MR + 1; m_ok = 1'b0;
        for (int i = 0; i <= MR; i++) begin
          rv[i] = ($urandom_range(0, 2) == 0);
          rd[i] = W'($urandom);
        end
        for (int i = 0; i <= MR; i++) begin
          if (rv[i]) begin
            m_n = i + 1; m_ok = 1'b1; m_data = rd[i];
            break;
          end
        end
        m_start = cyc;
        m_busy  = 1'b1;
        m_ptr   = (m_win + 1) % N;
        m_next  = cyc + 2 * m_n + 2;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h1, 4'h0, 4'b0001, 8'hA5, 4'h1, 4'h0, 8'hA5, 16'h0002, 3, 0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'b0001, 8'h01, 4'h1, 4'h0, 8'h01, 16'h0002, 3, 0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'b0001, 8'h02, 4'h2, 4'h0, 8'h02, 16'h0002, 3, 4};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'b0001, 8'h03, 4'h4, 4'h0, 8'h03, 16'h0002, 3, 4};
    tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'b0001, 8'h04, 4'h8, 4'h0, 8'h04, 16'h0002, 3, 4};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'b0001, 8'h05, 4'h1, 4'h0, 8'h05, 16'h0002, 3, 4};
    tbl[6]  = '{1'b0, 4'h2, 4'h0, 4'b0000, 8'h00, 4'h0, 4'h2, 8'h00, 16'h00AA, 9, 0};
    tbl[7]  = '{1'b0, 4'h6, 4'h0, 4'b0100, 8'h3C, 4'h4, 4'h0, 8'h3C, 16'h002A, 7, 0};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'b1000, 8'h77, 4'h8, 4'h0, 8'h77, 16'h00AA, 9, 0};
    tbl[9]  = '{1'b0, 4'hC, 4'h4, 4'b0001, 8'h5A, 4'h4, 4'h0, 8'h5A, 16'h0002, 3, 0};
    tbl[10] = '{1'b0, 4'h9, 4'h0, 4'b0001, 8'h6B, 4'h8, 4'h0, 8'h6B, 16'h0002, 3, 0};

    repeat (3) @(negedge clk);
    run_table();
    run_reset_in_wait();
    run_random(3000);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
